// File: rtl/bit_serial_alu_if.sv
// Start/done handshake bundle for bit_serial_alu.
// The master is the requesting CPU and the slave is the ALU.
interface bit_serial_alu_if #(
  parameter int WIDTH = 32
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_ctrl;
  logic             done_valid;
  logic             done_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;

  modport master (
    output start_valid, a, b, alu_ctrl, done_ready,
    input  start_ready, done_valid, result, zero, overflow
  );

  modport slave (
    input  start_valid, a, b, alu_ctrl, done_ready,
    output start_ready, done_valid, result, zero, overflow
  );
endinterface

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: one 1-bit slice walks the operands LSB-first, one bit per clock.
// Optional macro BIT_SERIAL_ALU_BACK2BACK_EN lets DONE accept the next request directly.
module bit_serial_alu #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  bit_serial_alu_if.slave  bus
);
  localparam int              IDX_W    = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, result_reg, result_next;
  logic [3:0]       ctrl_reg;
  logic             carry_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             zero_reg, overflow_reg;

  logic start_ready, done_valid, accept, last_bit;
  logic ai, bi, sum, carry_out, bit_res, ovf_bit, set_bit;

  assign accept   = bus.start_valid & start_ready;
  assign last_bit = (idx_reg == LAST_IDX);

  // Single ALU slice; the operand registers shift so bit i is always at [0].
  always_comb begin
    ai        = a_reg[0] ^ ctrl_reg[3];
    bi        = b_reg[0] ^ ctrl_reg[2];
    sum       = ai ^ bi ^ carry_reg;
    carry_out = (ai & bi) | ((ai ^ bi) & carry_reg);
    ovf_bit   = carry_reg ^ carry_out;
    set_bit   = ovf_bit ? ~sum : sum;
    case (ctrl_reg[1:0])
      2'b00:   bit_res = ai & bi;
      2'b01:   bit_res = ai | bi;
      2'b10:   bit_res = sum;
      default: bit_res = 1'b0;
    endcase
    result_next          = result_reg;
    result_next[idx_reg] = bit_res;
    // SLT: every bit was written as 0, only the LSB carries the set flag.
    if (last_bit && (ctrl_reg[1:0] == 2'b11))
      result_next[0] = set_bit;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = RUN;
      RUN:  if (last_bit) state_next = DONE;
      DONE: begin
        if (accept)
          state_next = RUN;
        else if (bus.done_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    start_ready = (state_reg == IDLE);
    done_valid  = (state_reg == DONE);
`ifdef BIT_SERIAL_ALU_BACK2BACK_EN
    if (state_reg == DONE)
      start_ready = bus.done_ready;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg        <= '0;
      b_reg        <= '0;
      ctrl_reg     <= '0;
      carry_reg    <= 1'b0;
      idx_reg      <= '0;
      result_reg   <= '0;
      zero_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else if (accept) begin
      a_reg        <= bus.a;
      b_reg        <= bus.b;
      ctrl_reg     <= bus.alu_ctrl;
      carry_reg    <= bus.alu_ctrl[2];
      idx_reg      <= '0;
      zero_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else if (state_reg == RUN) begin
      a_reg      <= a_reg >> 1;
      b_reg      <= b_reg >> 1;
      carry_reg  <= carry_out;
      idx_reg    <= idx_reg + 1'b1;
      result_reg <= result_next;
      if (last_bit) begin
        zero_reg     <= (result_next == '0);
        overflow_reg <= (ctrl_reg[1:0] == 2'b10) ? ovf_bit : 1'b0;
      end
    end else if ((state_reg == DONE) && bus.done_ready) begin
      zero_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end
  end

  assign bus.start_ready = start_ready;
  assign bus.done_valid  = done_valid;
  assign bus.result      = result_reg;
  assign bus.zero        = zero_reg;
  assign bus.overflow    = overflow_reg;
endmodule
